// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Imported by the controller and its wait counter.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int SRAM_DW       = 16;
    localparam int SRAM_AW_DEF   = 18;
    localparam int BASE_ADDR_DEF = 1024;
    localparam int WA_W_DEF      = SRAM_AW_DEF - 1;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts held cycles of one half-word access.
// 'last' marks the final cycle of the phase.
module sram_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into two timed half-word SRAM
// accesses (low half first) and stalls the pipeline via 'ready'.
module sram_mem_controller
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = BASE_ADDR_DEF,
    parameter int SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in
);

    localparam int WA_W = SRAM_AW - 1;

    state_t             state;
    logic               is_store;
    logic [WA_W-1:0]    wa;
    logic [WA_W-1:0]    wa_next;
    logic [SRAM_DW-1:0] wdata_hi;
    logic [31:0]        offset;
    logic               cnt_clr;
    logic               cnt_en;
    logic               last;

    // Out-of-range addresses wrap modulo the SRAM word count
    assign offset  = address - 32'(BASE_ADDR);
    assign wa_next = WA_W'(offset >> 2);

    assign ready = (state == DONE) |
                   ((state == IDLE) & ~rd_en & ~wr_en);

    assign cnt_clr = (state == IDLE) | last;
    assign cnt_en  = (state == LOW) | (state == HIGH);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .last(last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            is_store    <= 1'b0;
            wa          <= '0;
            wdata_hi    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_en | wr_en) begin
                        state       <= LOW;
                        is_store    <= wr_en;
                        wa          <= wa_next;
                        wdata_hi    <= write_data[31:16];
                        sram_addr   <= {wa_next, 1'b0};
                        sram_we_n   <= ~wr_en;
                        sram_dq_oe  <= wr_en;
                        sram_dq_out <= wr_en ? write_data[15:0] : '0;
                    end
                end
                LOW: begin
                    if (last) begin
                        if (!is_store) begin
                            read_data[15:0] <= sram_dq_in;
                        end
                        state       <= HIGH;
                        sram_addr   <= {wa, 1'b1};
                        sram_dq_out <= is_store ? wdata_hi : '0;
                    end
                end
                HIGH: begin
                    if (last) begin
                        if (!is_store) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                        state       <= DONE;
                        sram_addr   <= '0;
                        sram_we_n   <= 1'b1;
                        sram_dq_oe  <= 1'b0;
                        sram_dq_out <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural SRAM.
// Stimulus queues expected transactions; a monitor checks them.
module tb_sram_mem_controller;

    localparam int W  = 5;
    localparam int AW = 18;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [AW-1:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] mem [0:(1<<AW)-1];

    typedef struct {
        bit          store;
        logic [16:0] wa;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] rd_exp;
        bit          b2b;
    } exp_t;

    exp_t q[$];

    sram_mem_controller #(
        .WAIT_CYCLES(W),
        .BASE_ADDR(1024),
        .SRAM_AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .sram_addr(sram_addr),
        .sram_we_n(sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Asynchronous SRAM: combinational read, write while we_n low
    assign sram_dq_in = sram_we_n ? mem[sram_addr] : 16'h0000;
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    bit   active = 0;
    exp_t cur;
    int   k;
    int   pin_bad;
    int   last_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            active = 0;
        end else begin
            if (!active && !ready && q.size() > 0) begin
                active  = 1;
                cur     = q.pop_front();
                k       = 0;
                pin_bad = 0;
                if (cur.b2b) chk("b2b_start", cyc, last_done + 1);
            end
            if (active) begin
                if (k == 0) begin
                    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) pin_bad++;
                end else if (k <= 2 * W) begin
                    if (sram_addr !== {cur.wa, (k > W) ? 1'b1 : 1'b0})
                        pin_bad++;
                    if (cur.store) begin
                        if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1)
                            pin_bad++;
                        if (sram_dq_out !== ((k > W) ? cur.hi : cur.lo))
                            pin_bad++;
                    end else begin
                        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
                            pin_bad++;
                    end
                end
                if (ready) begin
                    chk("ready_low_cycles", k, 2 * W + 1);
                    chk("phase_pins", pin_bad, 0);
                    chk("done_pins", {sram_we_n, sram_dq_oe}, 2'b10);
                    chk("read_data", read_data, cur.rd_exp);
                    last_done = cyc;
                    active = 0;
                end else begin
                    k++;
                end
            end
        end
    end

    task automatic expect_tx(input bit st, input logic [16:0] wa,
                             input logic [31:0] d, input logic [31:0] rd,
                             input bit b2b);
        exp_t e;
        e.store  = st;
        e.wa     = wa;
        e.lo     = d[15:0];
        e.hi     = d[31:16];
        e.rd_exp = rd;
        e.b2b    = b2b;
        q.push_back(e);
    endtask

    task automatic issue(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input int drop_at);
        bit done = 0;
        rd_en = r;
        wr_en = w;
        address = a;
        write_data = d;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                if (n + 1 == drop_at) begin
                    rd_en = 0;
                    wr_en = 0;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: got no ready, expected ready");
        end
        @(posedge clk);
        #1;
        rd_en = 0;
        wr_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0;
        rd_en = 0;
        wr_en = 0;
        address = 0;
        write_data = 0;
        mem[4] = 16'hBEEF;
        mem[5] = 16'hDEAD;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_read_data", read_data, 0);
            chk("rst_we_n", sram_we_n, 1);
            chk("rst_oe", sram_dq_oe, 0);
            chk("rst_ready", ready, 1);
            chk("rst_addr", sram_addr, 0);
        end
        @(posedge clk);
        #1;
        rst = 1;
        idle(2);

        // store 0xDEADBEEF at 1032 -> half-words 4/5
        expect_tx(1, 17'd2, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 1, 1032, 32'hDEADBEEF, 0);
        idle(2);

        expect_tx(0, 17'd2, 32'h0, 32'hDEADBEEF, 0);
        issue(1, 0, 1032, 32'h0, 0);
        repeat (3) @(negedge clk);
        chk("read_data_held", read_data, 32'hDEADBEEF);
        idle(1);

        // back-to-back store then load at 1024
        expect_tx(1, 17'd0, 32'h12345678, 32'hDEADBEEF, 0);
        issue(0, 1, 1024, 32'h12345678, 0);
        expect_tx(0, 17'd0, 32'h0, 32'h12345678, 1);
        issue(1, 0, 1024, 32'h0, 0);
        idle(2);

        // both enables: handled as a store
        expect_tx(1, 17'd4, 32'hCAFEF00D, 32'h12345678, 0);
        issue(1, 1, 1040, 32'hCAFEF00D, 0);
        idle(1);
        expect_tx(0, 17'd4, 32'h0, 32'hCAFEF00D, 0);
        issue(1, 0, 1040, 32'h0, 0);
        idle(1);

        // rd_en withdrawn during HIGH
        expect_tx(0, 17'd2, 32'h0, 32'hDEADBEEF, 0);
        issue(1, 0, 1032, 32'h0, 8);
        idle(1);

        // wrap: 1024 + 4*2^17 maps to word 0
        expect_tx(1, 17'd0, 32'hA5A55A5A, 32'hDEADBEEF, 0);
        issue(0, 1, 1024 + 4 * (1 << 17), 32'hA5A55A5A, 0);
        idle(1);
        expect_tx(0, 17'd0, 32'h0, 32'hA5A55A5A, 0);
        issue(1, 0, 1024, 32'h0, 0);
        idle(1);

        // reset pulse in the middle of LOW
        wr_en = 1;
        address = 1032;
        write_data = 32'h11112222;
        repeat (3) @(posedge clk);
        #3;
        rst = 0;
        wr_en = 0;
        #1;
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_oe", sram_dq_oe, 0);
        chk("abort_addr", sram_addr, 0);
        chk("abort_dq_out", sram_dq_out, 0);
        chk("abort_read_data", read_data, 0);
        chk("abort_ready", ready, 1);
        @(posedge clk);
        #1;
        rst = 1;
        idle(2);

        expect_tx(0, 17'd4, 32'h0, 32'hCAFEF00D, 0);
        issue(1, 0, 1040, 32'h0, 0);
        idle(3);

        if (q.size() != 0 || active) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0",
                     q.size() + (active ? 1 : 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
